// File: rtl/switch_input_port_pkg.sv
// Shared definitions for the switch input peripheral: register offsets,
// STATUS bit positions and the button debounce state encoding.
package switch_input_port_pkg;

    localparam logic [31:0] OFF_DATA   = 32'd0;
    localparam logic [31:0] OFF_STATUS = 32'd4;
    localparam logic [31:0] OFF_LIVE   = 32'd8;

    localparam int ST_VALID   = 0;
    localparam int ST_OVERRUN = 1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    function automatic logic [31:0] status_word(input logic valid, input logic overrun);
        logic [31:0] w;
        w              = 32'd0;
        w[ST_VALID]    = valid;
        w[ST_OVERRUN]  = overrun;
        return w;
    endfunction

endpackage

// File: rtl/switch_input_port_if.sv
// Load-side bus between the processor datapath and the switch input peripheral.
interface switch_input_port_if;
    logic [31:0] address;
    logic        mem_read;
    logic [31:0] read_data;
    logic        hit;

    modport master (output address, output mem_read, input read_data, input hit);
    modport slave  (input address, input mem_read, output read_data, output hit);
endinterface

// File: rtl/switch_input_port_debouncer.sv
// Enter-button synchronizer and debouncer; emits one press pulse per physical
// press once the level has been stable for DEBOUNCE_CYCLES clocks.
module button_debouncer
    import switch_input_port_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press_pulse
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // The qualifying edge is the one on which the counter would step to DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd2);

    logic [1:0]       btn_sync_r;
    logic             btn_s;
    deb_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             press_s;

    assign btn_s       = btn_sync_r[1];
    assign press_pulse = press_s;

    // Two-flop synchronizer for the raw button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync_r <= 2'b00;
        end else begin
            btn_sync_r <= {btn_sync_r[0], button};
        end
    end

    // Debounce state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state, counter and press pulse
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        press_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_s) begin
                    state_s = PRESS_WAIT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = HELD;
                    press_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_s = RELEASE_WAIT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = HELD;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_s = HELD;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/switch_input_port.sv
// Memory-mapped switch input port: DATA/STATUS registers beside DataMemory.
// Define SWITCH_LIVE_READ_EN to add the undebounced LIVE register at BASE_ADDR+8.
module switch_input_port
    import switch_input_port_pkg::*;
#(
    parameter int          SW_WIDTH        = 8,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                button,
    switch_input_port_if.slave  bus,
    output logic                press_pending
);
    logic [SW_WIDTH-1:0] sw_meta_r, sw_sync_r;
    logic                press_pulse_s;
    logic [31:0]         data_r;
    logic                valid_r, overrun_r;
    logic                sel_data_s, sel_status_s;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .press_pulse (press_pulse_s)
    );

    assign sel_data_s    = bus.mem_read && (bus.address == (BASE_ADDR + OFF_DATA));
    assign sel_status_s  = bus.mem_read && (bus.address == (BASE_ADDR + OFF_STATUS));
    assign press_pending = valid_r;

`ifdef SWITCH_LIVE_READ_EN
    logic sel_live_s;
    assign sel_live_s = bus.mem_read && (bus.address == (BASE_ADDR + OFF_LIVE));
`endif

    // Two-flop synchronizer for the switch bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_r <= {SW_WIDTH{1'b0}};
            sw_sync_r <= {SW_WIDTH{1'b0}};
        end else begin
            sw_meta_r <= switches;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Capture on press; a DATA read on the same edge only retires the older value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r    <= 32'd0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (press_pulse_s) begin
            data_r    <= 32'(sw_sync_r);
            valid_r   <= 1'b1;
            overrun_r <= sel_data_s ? 1'b0 : valid_r;
        end else if (sel_data_s) begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r   <= valid_r;
            overrun_r <= overrun_r;
        end
    end

    // Combinational read mux, same timing as DataMemory
    always_comb begin
        bus.read_data = 32'd0;
        bus.hit       = 1'b0;
        if (sel_data_s) begin
            bus.read_data = data_r;
            bus.hit       = 1'b1;
        end else if (sel_status_s) begin
            bus.read_data = status_word(valid_r, overrun_r);
            bus.hit       = 1'b1;
        end
`ifdef SWITCH_LIVE_READ_EN
        else if (sel_live_s) begin
            bus.read_data = 32'(sw_sync_r);
            bus.hit       = 1'b1;
        end
`endif
        else begin
            bus.read_data = 32'd0;
            bus.hit       = 1'b0;
        end
    end

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with a short debounce window (4 cycles).
module tb_switch_input_port;
    import switch_input_port_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] switches;
    logic       button;
    logic       press_pending;
    int         n_cmp = 0;
    int         n_bad = 0;

    switch_input_port_if bus ();

    switch_input_port #(
        .SW_WIDTH        (8),
        .DEBOUNCE_CYCLES (16'd4),
        .BASE_ADDR       (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .switches      (switches),
        .button        (button),
        .bus           (bus),
        .press_pending (press_pending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                      input logic exp_hit);
        bus.mem_read = 1'b1;
        bus.address  = addr;
        #1;
        check({tag, "_data"}, bus.read_data, exp);
        check({tag, "_hit"}, {31'd0, bus.hit}, {31'd0, exp_hit});
    endtask

    task automatic idle();
        bus.mem_read = 1'b0;
        bus.address  = 32'd0;
    endtask

    task automatic press(input logic [7:0] sw);
        switches = sw;
        button   = 1'b1;
        tick(8);
        button   = 1'b0;
        tick(8);
    endtask

    initial begin
        rst = 1'b1; switches = 8'h00; button = 1'b0; idle();
        tick(2);
        check("rst_pending", {31'd0, press_pending}, 32'd0);
        rd("rst_status", BASE + 32'd4, 32'd0, 1'b1); idle();
        rst = 1'b0;
        tick(2);
        rd("post_rst_status", BASE + 32'd4, 32'd0, 1'b1); idle();

        // clean press: capture lands 2 sync + 4 debounce edges after the button edge
        switches = 8'hA5; button = 1'b1;
        tick(5);
        check("clean_pre", {31'd0, press_pending}, 32'd0);
        tick(1);
        check("clean_edge", {31'd0, press_pending}, 32'd1);
        tick(4);
        button = 1'b0;
        tick(8);
        rd("clean_status", BASE + 32'd4, 32'd1, 1'b1); idle();
        rd("clean_data", BASE, 32'h0000_00A5, 1'b1);
        tick(1); idle();
        rd("clean_status_after", BASE + 32'd4, 32'd0, 1'b1); idle();

        // glitches of 2 and 3 cycles are rejected
        switches = 8'h3C; button = 1'b1; tick(2); button = 1'b0; tick(10);
        check("glitch2_pending", {31'd0, press_pending}, 32'd0);
        button = 1'b1; tick(3); button = 1'b0; tick(10);
        check("glitch3_pending", {31'd0, press_pending}, 32'd0);
        rd("glitch_status", BASE + 32'd4, 32'd0, 1'b1); idle();

        // overrun: two presses without a read
        press(8'h11);
        press(8'h22);
        rd("ovr_status", BASE + 32'd4, 32'd3, 1'b1); idle();
        rd("ovr_data", BASE, 32'h0000_0022, 1'b1);
        tick(1); idle();
        rd("ovr_status_after", BASE + 32'd4, 32'd0, 1'b1); idle();
        check("ovr_pending_after", {31'd0, press_pending}, 32'd0);

        // DATA read on the same edge as a capture returns the old value
        press(8'h33);
        switches = 8'h44; button = 1'b1;
        tick(5);
        rd("simul_old", BASE, 32'h0000_0033, 1'b1);
        tick(1); idle();
        check("simul_pending", {31'd0, press_pending}, 32'd1);
        rd("simul_status", BASE + 32'd4, 32'd1, 1'b1); idle();
        rd("simul_new", BASE, 32'h0000_0044, 1'b1);
        tick(1); idle();
        button = 1'b0;
        tick(8);
        rd("simul_status_after", BASE + 32'd4, 32'd0, 1'b1); idle();

        // reset in PRESS_WAIT forces a fresh full debounce
        switches = 8'h55; button = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        check("rstmid_pre", {31'd0, press_pending}, 32'd0);
        tick(1);
        check("rstmid_edge", {31'd0, press_pending}, 32'd1);
        rd("rstmid_data", BASE, 32'h0000_0055, 1'b1);
        tick(1); idle();
        button = 1'b0;
        tick(8);

        // address decode
        press(8'h5A);
        rd("dec_plus12", BASE + 32'd12, 32'd0, 1'b0); idle();
        rd("dec_unaligned", BASE + 32'd1, 32'd0, 1'b0);
        tick(1); idle();
        switches = 8'hC3;
        tick(2);
`ifdef SWITCH_LIVE_READ_EN
        rd("dec_live", BASE + 32'd8, 32'h0000_00C3, 1'b1);
`else
        rd("dec_live", BASE + 32'd8, 32'd0, 1'b0);
`endif
        tick(1); idle();
        rd("dec_status_kept", BASE + 32'd4, 32'd1, 1'b1); idle();
        bus.address = BASE; bus.mem_read = 1'b0;
        #1;
        check("dec_noread_hit", {31'd0, bus.hit}, 32'd0);
        check("dec_noread_data", bus.read_data, 32'd0);
        rd("dec_data", BASE, 32'h0000_005A, 1'b1);
        tick(1); idle();
        check("dec_pending_after", {31'd0, press_pending}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
